// File: rtl/rv_pkg.sv
// RV32I encoding constants and the field bundle shared by the encoder and decode.
package rv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;
  localparam int unsigned FMT_W     = 3;
  localparam int unsigned ERR_CNT_W = 8;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  localparam logic [OPCODE_W-1:0] OP_REG    = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Raw fmt bits, since codes 6 and 7 must reach the legality check.
  typedef struct packed {
    logic [FMT_W-1:0]    fmt;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [XLEN-1:0]     imm;
  } inst_fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: builds the machine word and flags illegal bundles.
module inst_pack
  import rv_pkg::*;
(
  input  inst_fields_t    fields_i,
  output logic [XLEN-1:0] inst_c_o,
  output logic            illegal_c_o
);

  always_comb begin
    inst_c_o    = '0;
    illegal_c_o = 1'b0;
    case (fields_i.fmt)
      FMT_R: inst_c_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                         fields_i.funct3, fields_i.rd, fields_i.opcode};
      FMT_I: inst_c_o = {fields_i.imm[11:0], fields_i.rs1, fields_i.funct3,
                         fields_i.rd, fields_i.opcode};
      FMT_S: inst_c_o = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1,
                         fields_i.funct3, fields_i.imm[4:0], fields_i.opcode};
      FMT_B: begin
        inst_c_o    = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2,
                       fields_i.rs1, fields_i.funct3, fields_i.imm[4:1],
                       fields_i.imm[11], fields_i.opcode};
        illegal_c_o = fields_i.imm[0];
      end
      FMT_U: inst_c_o = {fields_i.imm[31:12], fields_i.rd, fields_i.opcode};
      FMT_J: begin
        inst_c_o    = {fields_i.imm[20], fields_i.imm[10:1], fields_i.imm[11],
                       fields_i.imm[19:12], fields_i.rd, fields_i.opcode};
        illegal_c_o = fields_i.imm[0];
      end
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: valid/ready front end around inst_pack, one output register stage,
// instruction-memory address tagging and sticky illegal-input accounting.
module inst_encoder
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FMT_W-1:0]     in_fmt,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]     in_rd,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [FUNCT3_W-1:0]  in_funct3,
  input  logic [FUNCT7_W-1:0]  in_funct7,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_inst,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_last,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  inst_fields_t          fields;
  logic [XLEN-1:0]       pack_inst;
  logic                  pack_illegal;
  logic                  accept;

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       inst_q, inst_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  last_q, last_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  assign fields = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                    rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  inst_pack u_pack (
    .fields_i    (fields),
    .inst_c_o    (pack_inst),
    .illegal_c_o (pack_illegal)
  );

  // The output slot is free when empty or when its word leaves this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    addr_d    = addr_q;
    last_d    = last_q;
    pc_d      = pc_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (pack_illegal) begin
        err_d = 1'b1;
        if (err_cnt_q != ERR_CNT_MAX) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end else begin
        valid_d = 1'b1;
        inst_d  = pack_inst;
        addr_d  = pc_q;
        last_d  = in_last;
        pc_d    = pc_q + ADDR_W'(4);
      end
      // A dropped final bundle still terminates the program.
      if (in_last) begin
        pc_d = BASE_ADDR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      addr_q    <= BASE_ADDR;
      last_q    <= 1'b0;
      pc_q      <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed spec vectors plus randomized traffic
// against a field-arithmetic reference model.
module tb_inst_encoder;
  import rv_pkg::*;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned ADDR_MOD = 1 << ADDR_W;

  logic              clk, rst;
  logic              in_valid, in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              out_valid, out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last, err;
  logic [7:0]        err_cnt;

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(12'h000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_last(out_last),
    .err(err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    int unsigned addr;
    bit          last;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned m_addr, m_err_cnt;
  bit          m_err;
  bit          ovr_en;
  logic [31:0] ovr_word;
  int          n_checks, n_errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding: place every field at its RV32I position, then mask and merge per format.
  function automatic logic [31:0] enc(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm);
    logic [31:0] w;
    w = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
    case (fmt)
      0: w = w | (32'(f7) << 25);
      1: w = (w & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
      2: w = (w & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      3: w = (w & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
             | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      4: w = (w & 32'hFFF) | (imm & 32'hFFFF_F000);
      default: w = (w & 32'hFFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
    endcase
    return w;
  endfunction

  task automatic model_accept();
    int          f;
    bit          legal;
    exp_t        e;
    f     = int'(in_fmt);
    legal = (f < 6) && !((f == 3 || f == 5) && in_imm[0]);
    if (legal) begin
      e.inst = ovr_en ? ovr_word
                      : enc(f, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      e.addr = m_addr;
      e.last = in_last;
      sb_q.push_back(e);
      m_addr = (m_addr + 4) % ADDR_MOD;
    end else begin
      m_err = 1'b1;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    if (in_last) m_addr = 0;
    ovr_en = 1'b0;
  endtask

  // Inputs change at posedge+1; the handshake is judged mid-cycle and recorded at the edge.
  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) model_accept();
    #1;
  endtask

  task automatic send();
    bit acc;
    int n;
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      n_checks++;
      n_errs++;
      $display("FAIL accept_timeout: bundle not accepted after %0d cycles", n);
    end
  endtask

  task automatic bundle(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
  endtask

  task automatic rand_fields(input bit legal_only);
    in_fmt    = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    in_imm    = $urandom;
    in_last   = 1'b0;
    if ((in_fmt == 3'd3 || in_fmt == 3'd5) && (legal_only || $urandom_range(0, 3) != 0))
      in_imm[0] = 1'b0;
  endtask

  // Monitor: interface and held word against the scoreboard head, every mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'((sb_q.size() == 0) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), m_err_cnt);
      if (out_valid && sb_q.size() != 0) begin
        chk("out_inst", out_inst, sb_q[0].inst);
        chk("out_addr", 32'(out_addr), sb_q[0].addr);
        chk("out_last", 32'(out_last), 32'(sb_q[0].last));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    bit acc;
    n_checks = 0; n_errs = 0;
    m_addr = 0; m_err = 1'b0; m_err_cnt = 0;
    ovr_en = 1'b0; ovr_word = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    bundle(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;

    // Directed R, I, U back to back.
    bundle(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h0, 32'h0, 1'b0);
    ovr_en = 1'b1; ovr_word = 32'h002081b3; send();
    bundle(FMT_I, OP_IMM, 5'd2, 5'd1, 5'd0, 3'd0, 7'h0, 32'h54, 1'b0);
    ovr_en = 1'b1; ovr_word = 32'h05408113; send();
    bundle(FMT_U, OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0002_3000, 1'b0);
    ovr_en = 1'b1; ovr_word = 32'h000230b7; send();
    in_valid = 1'b0; cycle(acc);

    // Branch, then the same branch with an odd offset.
    bundle(FMT_B, OP_BRANCH, 5'd0, 5'd2, 5'd1, 3'd1, 7'h0, 32'hFFFF_FFF8, 1'b0);
    ovr_en = 1'b1; ovr_word = 32'hfe111ce3; send();
    bundle(FMT_B, OP_BRANCH, 5'd0, 5'd2, 5'd1, 3'd1, 7'h0, 32'hFFFF_FFF9, 1'b0);
    send();
    in_valid = 1'b0; cycle(acc); cycle(acc);

    // Backpressure: one word held, next bundle stalls for five cycles.
    out_ready = 1'b0;
    bundle(FMT_S, OP_STORE, 5'd0, 5'd5, 5'd6, 3'd2, 7'h0, 32'h0000_07F0, 1'b0);
    send();
    bundle(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h000F_F7FE, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      chk("bp_no_accept", 32'(acc), 32'h0);
    end
    out_ready = 1'b1;
    send();
    in_valid = 1'b0; cycle(acc); cycle(acc);

    // Address wrap, then a program end.
    for (int i = 0; i < 1030; i++) begin
      rand_fields(1'b1);
      send();
    end
    rand_fields(1'b1); in_last = 1'b1; send();
    rand_fields(1'b1); send();
    in_valid = 1'b0; cycle(acc);

    // Randomized traffic with backpressure, illegal bundles and program ends.
    for (int i = 0; i < 2000; i++) begin
      rand_fields(1'b0);
      in_last   = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle(acc);
    chk("drain", 32'(sb_q.size()), 32'h0);

    // Reset between edges while a word is held.
    out_ready = 1'b0;
    rand_fields(1'b1); send();
    in_valid = 1'b0; cycle(acc);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_inst", out_inst, 32'h0);
    chk("arst_out_addr", 32'(out_addr), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_err_cnt", 32'(err_cnt), 32'h0);
    sb_q.delete(); m_addr = 0; m_err = 1'b0; m_err_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    bundle(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h0, 32'h0, 1'b0);
    ovr_en = 1'b1; ovr_word = 32'h002081b3; send();
    in_valid = 1'b0;
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) cycle(acc);
    chk("final_drain", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Packs discrete RISC-V RV32I instruction fields into a 32-bit machine word, the inverse of the core's decode block.
- Used by the on-chip program loader and by decode regression benches to generate instruction streams.
- Fields enter through a valid/ready input port. One registered output stage holds the word, and an address counter tags each word with its instruction-memory byte address.

Parameters:
- ADDR_W, 12, width of the instruction-memory byte address and of the address counter.
- BASE_ADDR, 0, address assigned to the first word after reset or after in_last.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the field bundle is valid.
- in_ready  out  1  the encoder can accept a bundle this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  in  7  opcode field.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R format only).
- in_imm  in  32  immediate, sign-extended value. For U format, bits 31:12 are used.
- in_last  in  1  final instruction of a program.
- out_valid  out  1  out_inst and out_addr are valid.
- out_ready  in  1  the consumer accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- out_last  out  1  in_last carried with this word.
- err  out  1  sticky illegal-input flag.
- err_cnt  out  8  number of dropped bundles; saturates at 255.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_last=0, err=0, err_cnt=0.
  - Address counter = BASE_ADDR.
- in_ready = !out_valid || out_ready. It is combinational and never depends on in_valid.
- A bundle is accepted when in_valid && in_ready. The encoded word appears on out_inst the next cycle with out_valid=1, so latency is 1 cycle.
- A word is consumed when out_valid && out_ready.
  - If a new bundle is accepted in the same cycle, the register reloads and out_valid stays 1, giving back-to-back throughput of 1 word per cycle.
  - Otherwise out_valid drops to 0.
- While out_valid && !out_ready, all out_* signals hold stable.
- Packing, with the opcode always in bits 6:0:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U: imm[31:12] | rd.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Immediate checks:
  - imm bits above the format's range are not checked.
  - The format's LSB constraint is checked: B requires imm[0]=0, and J requires imm[0]=0.
- Illegal bundle (fmt 6 or 7, or B/J with imm[0]=1):
  - The bundle is still accepted (handshake completes) but dropped. No output word is produced and the address counter does not advance.
  - err is set to 1 and err_cnt increments, saturating at 255.
  - If the dropped bundle carried in_last, the counter still resets to BASE_ADDR.
- Address counter:
  - Advances by 4 on each legal accept.
  - out_addr takes the pre-increment value.
  - Wraps modulo 2^ADDR_W with no error.
  - After an accept with in_last=1, the counter returns to BASE_ADDR.
- err and err_cnt clear only on rst.
- Reset asserted mid-transfer: the pending word is discarded, and out_valid falls asynchronously.

Decomposition:
- Shared package rv_pkg holds:
  - the format enum (FMT_R..FMT_J);
  - opcode constants OP_REG=7'h33, OP_IMM=7'h13, OP_LUI=7'h37, OP_BRANCH=7'h63, OP_STORE=7'h23, OP_JAL=7'h6F;
  - field-position constants shared with decode.
- One combinational sub-module, inst_pack (fields in, 32-bit word plus illegal flag out), is natural. inst_encoder wraps it with the handshake register, address counter and error logic.

Test Plan:
- R packing: fmt=R, op=33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_inst=002081b3, out_addr=0x000, 1 cycle after accept.
- I and U packing, back-to-back with out_ready=1:
  - ADDI x2,x1,0x54 -> 05408113 at addr 0x004.
  - Then LUI x1 with imm=0x00023000 -> 000230b7 at addr 0x008.
  - out_valid stays 1 throughout.
- B packing: fmt=B, op=63, f3=1, rs1=2, rs2=1, imm=-8 (0xFFFFFFF8) -> fe111ce3. Same bundle with imm=-7 -> dropped, err=1, err_cnt=1, address unchanged.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_inst/out_addr stable. On out_ready=1 the next word follows in the next cycle.
- Wrap and last:
  - ADDR_W=4 with 5 legal words -> addresses 0, 4, 8, C, 0.
  - Word sent with in_last=1 -> out_last=1, and the next word is at BASE_ADDR.
- Async reset: assert rst between clock edges while out_valid=1 -> out_valid=0 immediately, and err, err_cnt and the counter are cleared.
